// File: rtl/smul_pipe_if.sv
// Operand/result handshake bundle for smul_pipe. With SMUL_ACC_EN defined the
// bundle also carries acc_clr, and OW must then be AW+BW+GW.
interface smul_pipe_if #(
  parameter int AW = 8,
  parameter int BW = 9,
  parameter int OW = AW + BW
);
  // valid/ready: a beat moves on a rising edge where valid and ready are both 1;
  // the source keeps valid and its payload stable until that edge.
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          b_signed;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out;

`ifdef SMUL_ACC_EN
  logic          acc_clr;

  modport master (
    output in_valid, a, b, b_signed, acc_clr, out_ready,
    input  in_ready, out_valid, out
  );
  modport slave (
    input  in_valid, a, b, b_signed, acc_clr, out_ready,
    output in_ready, out_valid, out
  );
`else
  modport master (
    output in_valid, a, b, b_signed, out_ready,
    input  in_ready, out_valid, out
  );
  modport slave (
    input  in_valid, a, b, b_signed, out_ready,
    output in_ready, out_valid, out
  );
`endif
endinterface

// File: rtl/smul_pipe.sv
// Pipelined unsigned x (signed|unsigned) Baugh-Wooley multiplier with valid/ready on
// both sides. Define SMUL_ACC_EN to add acc_clr and a wrapping accumulator (MAC).
module smul_pipe #(
  parameter int AW     = 8,
  parameter int BW     = 9,
  parameter int STAGES = 3,
  parameter int GW     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  smul_pipe_if.slave bus
);
  localparam int PW     = AW + BW;
  localparam int NT     = (STAGES > 2) ? STAGES - 2 : 0;
  localparam int NTD    = (NT > 0) ? NT : 1;
  localparam int FIN_LO = (STAGES > 2) ? BW : 0;
  // Baugh-Wooley constant for the inverted sign row, reduced modulo 2^PW.
  localparam logic [PW-1:0] CORR = (PW'(1) << (BW - 1)) | (PW'(1) << (PW - 1));

`ifdef SMUL_ACC_EN
  localparam int OW = PW + GW;
  typedef struct packed { logic bs; logic clr; } side_t;
`else
  localparam int OW = PW;
  typedef struct packed { logic bs; } side_t;
`endif

  typedef struct packed {
    logic [PW-1:0] s;
    logic [PW-1:0] c;
  } cs_t;

  if (AW < 2 || BW < 2 || STAGES < 1 || STAGES > 4 || GW < 1) begin : g_bad_param
    $error("smul_pipe: parameter out of range");
  end

  function automatic logic [PW-1:0] pp_row(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                           input logic bs, input int j);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) begin
      r[i+j] = (bs && j == BW - 1) ? ~(a[i] & b[j]) : (a[i] & b[j]);
    end
    return r;
  endfunction

  function automatic cs_t cs_init(input logic bs);
    cs_t r;
    r.s = bs ? CORR : '0;
    r.c = '0;
    return r;
  endfunction

  // Folds partial-product rows lo..hi-1 into the carry-save pair with 3:2 compressors.
  function automatic cs_t csa_rows(input cs_t in, input logic [AW-1:0] a, input logic [BW-1:0] b,
                                   input logic bs, input int lo, input int hi);
    cs_t           r;
    logic [PW-1:0] row;
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    r = in;
    for (int j = 0; j < BW; j++) begin
      if (j >= lo && j < hi) begin
        row = pp_row(a, b, bs, j);
        s   = r.s ^ r.c ^ row;
        c   = ((r.s & r.c) | (r.s & row) | (r.c & row)) << 1;
        r.s = s;
        r.c = c;
      end
    end
    return r;
  endfunction

  logic  adv;
  logic  take;
  side_t in_side;

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;
  assign take         = bus.in_valid & adv;
`ifdef SMUL_ACC_EN
  assign in_side = '{bs: bus.b_signed, clr: bus.acc_clr};
`else
  assign in_side = '{bs: bus.b_signed};
`endif

  logic          fin_vld;
  side_t         fin_side;
  logic [AW-1:0] fin_a;
  logic [BW-1:0] fin_b;
  cs_t           fin_cs_in;

  if (STAGES == 1) begin : g_direct
    assign fin_vld   = take;
    assign fin_side  = in_side;
    assign fin_a     = bus.a;
    assign fin_b     = bus.b;
    assign fin_cs_in = cs_init(bus.b_signed);
  end else begin : g_pipe
    // Index 0 is the operand register; 1..NT each fold one slice of the rows.
    logic          vld_q  [NT+1];
    side_t         side_q [NT+1];
    logic [AW-1:0] a_q    [NT+1];
    logic [BW-1:0] b_q    [NT+1];
    cs_t           cs_q   [NT+1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k <= NT; k++) vld_q[k] <= 1'b0;
      end else if (adv) begin
        vld_q[0]  <= take;
        side_q[0] <= in_side;
        a_q[0]    <= bus.a;
        b_q[0]    <= bus.b;
        cs_q[0]   <= cs_init(bus.b_signed);
        for (int k = 1; k <= NT; k++) begin
          vld_q[k]  <= vld_q[k-1];
          side_q[k] <= side_q[k-1];
          a_q[k]    <= a_q[k-1];
          b_q[k]    <= b_q[k-1];
          cs_q[k]   <= csa_rows(cs_q[k-1], a_q[k-1], b_q[k-1], side_q[k-1].bs,
                                (k - 1) * BW / NTD, k * BW / NTD);
        end
      end
    end

    assign fin_vld   = vld_q[NT];
    assign fin_side  = side_q[NT];
    assign fin_a     = a_q[NT];
    assign fin_b     = b_q[NT];
    assign fin_cs_in = cs_q[NT];
  end

  cs_t           fin_cs;
  logic [PW-1:0] prod;
  logic [OW-1:0] out_d;
  logic [OW-1:0] out_q;
  logic          out_vld_q;

  assign fin_cs = csa_rows(fin_cs_in, fin_a, fin_b, fin_side.bs, FIN_LO, BW);
  assign prod   = fin_cs.s + fin_cs.c;

`ifdef SMUL_ACC_EN
  always_comb begin
    out_d = fin_side.clr ? '0 : out_q;
    out_d = out_d + {{GW{fin_side.bs & prod[PW-1]}}, prod};
  end
`else
  assign out_d = prod;
`endif

  // Loading only on a valid beat keeps a stalled result from being added twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (adv) begin
      out_vld_q <= fin_vld;
      if (fin_vld) out_q <= out_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out       = out_q;
endmodule
